fwd_hazard_unit: RTL and testbench

- Parametrised forwarding and hazard unit for the pipelined RV32 core.
- Replaces the fixed two-stage, two-source forwarding selector. It supports NUM_STAGES result-carrying stages and NUM_SRC source operands.
- Adds load-use stall generation and a sequential tracker for one outstanding long-latency (LL) operation such as mul/div. The tracker provides RAW, WAW and structural stalls and an LL forwarding path.
- Sits beside the ID/EX pipeline registers. Its outputs drive the EX operand muxes and the PC/IF-ID stall logic.

---
 rtl/fwd_hazard_if.sv | 39 +++
 rtl/fwd_hazard_unit.sv | 131 +++++++++++++
 tb/tb_fwd_hazard_unit.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fwd_hazard_if.sv
// Bundle of ID/EX hazard-detection inputs and forward/stall outputs shared by
// the decode stage, the EX operand muxes and the forwarding/hazard unit.
interface fwd_hazard_if #(
  parameter int NUM_SRC    = 2,
  parameter int NUM_STAGES = 2,
  parameter int LAT_W      = 4,
  parameter int SEL_W      = $clog2(NUM_STAGES + 2)
);
  logic [NUM_SRC*5-1:0]     id_rs;
  logic [NUM_SRC-1:0]       id_rs_used;
  logic [4:0]               id_rd;
  logic                     id_regwrite;
  logic                     id_is_ll;
  logic [NUM_SRC*5-1:0]     ex_rs;
  logic [NUM_STAGES*5-1:0]  stage_rd;
  logic [NUM_STAGES-1:0]    stage_regwrite;
  logic [NUM_STAGES-1:0]    stage_is_load;
  logic                     ll_issue;
  logic [4:0]               ll_rd;
  logic [LAT_W-1:0]         ll_latency;
  logic [NUM_SRC*SEL_W-1:0] fwd_sel;
  logic                     stall;
  logic                     ll_busy;
  logic                     ll_wb;
  logic [4:0]               ll_wb_rd;
  logic                     ll_err;

  modport master (
    output id_rs, id_rs_used, id_rd, id_regwrite, id_is_ll, ex_rs,
           stage_rd, stage_regwrite, stage_is_load, ll_issue, ll_rd, ll_latency,
    input  fwd_sel, stall, ll_busy, ll_wb, ll_wb_rd, ll_err
  );

  modport slave (
    input  id_rs, id_rs_used, id_rd, id_regwrite, id_is_ll, ex_rs,
           stage_rd, stage_regwrite, stage_is_load, ll_issue, ll_rd, ll_latency,
    output fwd_sel, stall, ll_busy, ll_wb, ll_wb_rd, ll_err
  );
endinterface

// File: rtl/fwd_hazard_unit.sv
// Operand forwarding selects, load-use / long-latency stalls and a tracker for
// one outstanding long-latency (mul/div) operation.
module fwd_hazard_unit #(
  parameter int NUM_SRC    = 2,
  parameter int NUM_STAGES = 2,
  parameter int LAT_W      = 4,
  parameter int SEL_W      = $clog2(NUM_STAGES + 2)
) (
  input logic         clk,
  input logic         rst,
  fwd_hazard_if.slave bus
);

  typedef enum logic [1:0] {IDLE, BUSY, WB} ll_state_t;

  ll_state_t          state_q, state_d;
  logic [LAT_W-1:0]   cnt_q, cnt_d;
  logic [4:0]         ll_rd_q, ll_rd_d;
  logic               ll_err_q, ll_err_d;

  logic               ll_wb;
  logic [4:0]         ll_wb_rd;
  logic               busy_st;
  logic               load_use;
  logic               ll_raw;
  logic               ll_waw;
  logic               ll_struct;
  logic [NUM_SRC*SEL_W-1:0] fwd_sel_c;
  logic               unused_load_hi;

  // A latency of zero behaves like a single-cycle op.
  function automatic logic [LAT_W-1:0] eff_lat(input logic [LAT_W-1:0] lat);
    return (lat == '0) ? LAT_W'(1) : lat;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      ll_rd_q  <= '0;
      ll_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ll_rd_q  <= ll_rd_d;
      ll_err_q <= ll_err_d;
    end
  end

  always_comb begin : ll_next
    logic [LAT_W-1:0] lat;
    state_d  = state_q;
    cnt_d    = cnt_q;
    ll_rd_d  = ll_rd_q;
    ll_err_d = ll_err_q;
    lat      = eff_lat(bus.ll_latency);
    case (state_q)
      BUSY: begin
        if (bus.ll_issue) ll_err_d = 1'b1;
        if (cnt_q == '0) state_d = WB;
        else             cnt_d   = cnt_q - LAT_W'(1);
      end
      IDLE, WB: begin
        if (bus.ll_issue) begin
          ll_rd_d = bus.ll_rd;
          if (lat == LAT_W'(1)) begin
            state_d = WB;
            cnt_d   = '0;
          end else begin
            state_d = BUSY;
            cnt_d   = lat - LAT_W'(2);
          end
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy_st  = (state_q == BUSY);
  assign ll_wb    = (state_q == WB);
  assign ll_wb_rd = ll_wb ? ll_rd_q : 5'd0;

  // Youngest matching stage wins; the LL writeback is the lowest-priority source.
  always_comb begin : fwd_mux
    logic [4:0]       rs;
    logic [SEL_W-1:0] sel;
    fwd_sel_c = '0;
    for (int s = 0; s < NUM_SRC; s++) begin
      rs  = bus.ex_rs[s*5 +: 5];
      sel = '0;
      for (int j = NUM_STAGES - 1; j >= 0; j--) begin
        if (bus.stage_regwrite[j] && bus.stage_rd[j*5 +: 5] != 5'd0 &&
            bus.stage_rd[j*5 +: 5] == rs)
          sel = SEL_W'(j + 1);
      end
      if (sel == '0 && ll_wb && ll_wb_rd != 5'd0 && ll_wb_rd == rs)
        sel = SEL_W'(NUM_STAGES + 1);
      fwd_sel_c[s*SEL_W +: SEL_W] = sel;
    end
  end

  always_comb begin : hazard
    logic ld_hit;
    logic ll_hit;
    ld_hit = 1'b0;
    ll_hit = 1'b0;
    for (int s = 0; s < NUM_SRC; s++) begin
      if (bus.id_rs_used[s]) begin
        if (bus.id_rs[s*5 +: 5] == bus.stage_rd[4:0]) ld_hit = 1'b1;
        if (bus.id_rs[s*5 +: 5] == ll_rd_q)           ll_hit = 1'b1;
      end
    end
    load_use  = bus.stage_is_load[0] && bus.stage_regwrite[0] &&
                bus.stage_rd[4:0] != 5'd0 && ld_hit;
    ll_raw    = busy_st && ll_rd_q != 5'd0 && ll_hit;
    ll_waw    = busy_st && bus.id_regwrite && ll_rd_q != 5'd0 && bus.id_rd == ll_rd_q;
    ll_struct = busy_st && bus.id_is_ll;
  end

  assign unused_load_hi = &{1'b0, bus.stage_is_load};

  assign bus.fwd_sel  = fwd_sel_c;
  assign bus.stall    = load_use | ll_raw | ll_waw | ll_struct;
  assign bus.ll_busy  = (state_q != IDLE);
  assign bus.ll_wb    = ll_wb;
  assign bus.ll_wb_rd = ll_wb_rd;
  assign bus.ll_err   = ll_err_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed and randomized bench for fwd_hazard_unit against a cycle-countdown
// reference model of the long-latency tracker and rule-level hazard checks.
module tb_fwd_hazard_unit;
  localparam int NS  = 3;
  localparam int NST = 3;
  localparam int LW  = 4;
  localparam int SW  = $clog2(NST + 2);

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  // Model: cycles left until (and including) the LL writeback cycle.
  int         m_rem;
  logic [4:0] m_rd;
  bit         m_err;

  fwd_hazard_if #(.NUM_SRC(NS), .NUM_STAGES(NST), .LAT_W(LW)) bus_if ();

  fwd_hazard_unit #(.NUM_SRC(NS), .NUM_STAGES(NST), .LAT_W(LW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_sel(input int s);
    logic [4:0] rs;
    rs = bus_if.ex_rs[s*5 +: 5];
    for (int j = 0; j < NST; j++)
      if (bus_if.stage_regwrite[j] && bus_if.stage_rd[j*5 +: 5] != 0 &&
          bus_if.stage_rd[j*5 +: 5] == rs)
        return j + 1;
    if (m_rem == 1 && m_rd != 0 && m_rd == rs) return NST + 1;
    return 0;
  endfunction

  function automatic logic [31:0] exp_stall();
    bit st;
    st = 0;
    for (int s = 0; s < NS; s++) begin
      if (bus_if.id_rs_used[s]) begin
        if (bus_if.stage_is_load[0] && bus_if.stage_regwrite[0] &&
            bus_if.stage_rd[4:0] != 0 && bus_if.stage_rd[4:0] == bus_if.id_rs[s*5 +: 5])
          st = 1;
        if (m_rem >= 2 && m_rd != 0 && m_rd == bus_if.id_rs[s*5 +: 5]) st = 1;
      end
    end
    if (m_rem >= 2 && bus_if.id_regwrite && m_rd != 0 && bus_if.id_rd == m_rd) st = 1;
    if (m_rem >= 2 && bus_if.id_is_ll) st = 1;
    return {31'd0, st};
  endfunction

  task automatic check_all();
    for (int s = 0; s < NS; s++)
      chk($sformatf("fwd_sel[%0d]", s), 32'(bus_if.fwd_sel[s*SW +: SW]), exp_sel(s));
    chk("stall",    32'(bus_if.stall),    exp_stall());
    chk("ll_busy",  32'(bus_if.ll_busy),  32'(m_rem >= 1));
    chk("ll_wb",    32'(bus_if.ll_wb),    32'(m_rem == 1));
    chk("ll_wb_rd", 32'(bus_if.ll_wb_rd), (m_rem == 1) ? 32'(m_rd) : 32'd0);
    chk("ll_err",   32'(bus_if.ll_err),   32'(m_err));
  endtask

  task automatic model_edge();
    if (rst) begin
      m_rem = 0;
      m_rd  = 0;
      m_err = 0;
    end else if (bus_if.ll_issue && m_rem <= 1) begin
      m_rem = (bus_if.ll_latency == 0) ? 1 : int'(bus_if.ll_latency);
      m_rd  = bus_if.ll_rd;
    end else begin
      if (bus_if.ll_issue) m_err = 1;
      if (m_rem > 0) m_rem--;
    end
  endtask

  // Inputs are set at the falling edge; check mid-cycle, then advance.
  task automatic step();
    #1 check_all();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    bus_if.id_rs          = '0;
    bus_if.id_rs_used     = '0;
    bus_if.id_rd          = '0;
    bus_if.id_regwrite    = 1'b0;
    bus_if.id_is_ll       = 1'b0;
    bus_if.ex_rs          = '0;
    bus_if.stage_rd       = '0;
    bus_if.stage_regwrite = '0;
    bus_if.stage_is_load  = '0;
    bus_if.ll_issue       = 1'b0;
    bus_if.ll_rd          = '0;
    bus_if.ll_latency     = '0;
  endtask

  task automatic issue(input logic [4:0] rd, input logic [LW-1:0] lat);
    bus_if.ll_issue   = 1'b1;
    bus_if.ll_rd      = rd;
    bus_if.ll_latency = lat;
    step();
    bus_if.ll_issue   = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    m_rem = 0;
    m_rd  = 0;
    m_err = 0;
    rst   = 1'b1;
    clear_inputs();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    step();
    rst = 1'b0;
    #1 chk("reset_busy", 32'(bus_if.ll_busy), 0);
    chk("reset_stall", 32'(bus_if.stall), 0);
    step();

    // Forwarding priority and x0 handling
    bus_if.stage_rd       = {5'd0, 5'd5, 5'd5};
    bus_if.stage_regwrite = 3'b011;
    bus_if.ex_rs          = {5'd0, 5'd0, 5'd5};
    #1 chk("fwd_young", 32'(bus_if.fwd_sel[SW-1:0]), 1);
    step();
    bus_if.stage_regwrite = 3'b010;
    #1 chk("fwd_older", 32'(bus_if.fwd_sel[SW-1:0]), 2);
    step();
    bus_if.stage_rd = '0;
    bus_if.stage_regwrite = 3'b111;
    #1 chk("fwd_x0", 32'(bus_if.fwd_sel[SW-1:0]), 0);
    step();
    bus_if.stage_rd = {5'd12, 5'd0, 5'd0};
    bus_if.ex_rs    = {5'd12, 5'd0, 5'd0};
    #1 chk("fwd_src2_stage2", 32'(bus_if.fwd_sel[2*SW +: SW]), 3);
    step();
    clear_inputs();

    // Load-use
    bus_if.stage_is_load  = 3'b001;
    bus_if.stage_regwrite = 3'b001;
    bus_if.stage_rd       = {5'd0, 5'd0, 5'd7};
    bus_if.id_rs          = {5'd0, 5'd7, 5'd0};
    bus_if.id_rs_used     = 3'b010;
    #1 chk("load_use", 32'(bus_if.stall), 1);
    step();
    bus_if.id_rs_used = 3'b101;
    #1 chk("load_use_unused", 32'(bus_if.stall), 0);
    step();
    bus_if.id_rs      = {5'd7, 5'd0, 5'd0};
    bus_if.id_rs_used = 3'b100;
    #1 chk("load_use_src2", 32'(bus_if.stall), 1);
    step();
    clear_inputs();

    // LL op latency 4, ID reading x9
    bus_if.id_rs      = {5'd0, 5'd0, 5'd9};
    bus_if.id_rs_used = 3'b001;
    issue(5'd9, 4'd4);
    for (int k = 1; k <= 4; k++) begin
      bus_if.ex_rs = (k == 4) ? {5'd0, 5'd0, 5'd9} : '0;
      #1 chk($sformatf("ll4_busy_t%0d", k), 32'(bus_if.ll_busy), 1);
      chk($sformatf("ll4_wb_t%0d", k), 32'(bus_if.ll_wb), 32'(k == 4));
      chk($sformatf("ll4_stall_t%0d", k), 32'(bus_if.stall), 32'(k < 4));
      if (k == 4) begin
        chk("ll4_wb_rd", 32'(bus_if.ll_wb_rd), 9);
        chk("ll4_fwd", 32'(bus_if.fwd_sel[SW-1:0]), NST + 1);
      end
      step();
    end
    #1 chk("ll4_idle", 32'(bus_if.ll_busy), 0);
    clear_inputs();

    // Structural, WAW and issue-while-busy
    issue(5'd9, 4'd6);
    bus_if.id_is_ll = 1'b1;
    #1 chk("ll_struct", 32'(bus_if.stall), 1);
    step();
    bus_if.id_is_ll    = 1'b0;
    bus_if.id_regwrite = 1'b1;
    bus_if.id_rd       = 5'd9;
    #1 chk("ll_waw", 32'(bus_if.stall), 1);
    step();
    bus_if.id_regwrite = 1'b0;
    issue(5'd3, 4'd2);
    #1 chk("ll_err_set", 32'(bus_if.ll_err), 1);
    for (int k = 0; k < 8; k++) step();
    #1 chk("ll_err_sticky", 32'(bus_if.ll_err), 1);
    rst = 1'b1;
    step();
    rst = 1'b0;

    // Latency 0/1 and back-to-back issue in the WB cycle
    issue(5'd4, 4'd0);
    #1 chk("lat0_wb", 32'(bus_if.ll_wb), 1);
    issue(5'd6, 4'd1);
    #1 chk("lat1_wb", 32'(bus_if.ll_wb_rd), 6);
    issue(5'd8, 4'd3);
    step();
    step();
    #1 chk("b2b_wb", 32'(bus_if.ll_wb_rd), 8);
    chk("b2b_no_err", 32'(bus_if.ll_err), 0);
    step();

    // Reset during BUSY
    bus_if.id_rs      = {5'd0, 5'd0, 5'd9};
    bus_if.id_rs_used = 3'b001;
    issue(5'd9, 4'd8);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1 chk("rst_busy_clr", 32'(bus_if.ll_busy), 0);
    chk("rst_stall_clr", 32'(bus_if.stall), 0);
    for (int k = 0; k < 10; k++) step();
    clear_inputs();

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      for (int s = 0; s < NS; s++) begin
        bus_if.id_rs[s*5 +: 5] = 5'($urandom_range(0, 3));
        bus_if.ex_rs[s*5 +: 5] = 5'($urandom_range(0, 3));
      end
      for (int j = 0; j < NST; j++) bus_if.stage_rd[j*5 +: 5] = 5'($urandom_range(0, 3));
      bus_if.id_rs_used     = NS'($urandom);
      bus_if.stage_regwrite = NST'($urandom);
      bus_if.stage_is_load  = NST'($urandom);
      bus_if.id_rd          = 5'($urandom_range(0, 3));
      bus_if.id_regwrite    = 1'($urandom);
      bus_if.id_is_ll       = ($urandom_range(0, 3) == 0);
      bus_if.ll_issue       = ($urandom_range(0, 3) == 0);
      bus_if.ll_rd          = 5'($urandom_range(0, 3));
      bus_if.ll_latency     = ($urandom_range(0, 3) == 0) ? LW'($urandom) : LW'($urandom_range(0, 3));
      rst                   = ($urandom_range(0, 199) == 0);
      step();
    end
    rst = 1'b0;
    clear_inputs();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
